led_sequencer: RTL
==================

Name: led_sequencer

Overview:
- Programmable pattern scheduler that drives the 8-bit LED PIO data register over an Avalon-MM master port.
- Software loads up to DEPTH patterns, a dwell time and a step count through an Avalon-MM slave port, then sets RUN.
- The block writes each pattern to the PIO (word address PIO_ADDR) in turn and holds it for the dwell time.
- It either stops after the last step or loops.

Parameters:
DEPTH, 8, number of pattern slots (power of 2, max 8)
CNT_W, 24, width of the dwell counter
PIO_ADDR, 0, word address of the LED PIO data register driven on m_address

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
address  input  4  slave word address
chipselect  input  1  slave select
write_n  input  1  slave write strobe, active-low
writedata  input  32  slave write data
readdata  output  32  slave read data, combinational from address
m_address  output  2  master word address, constant PIO_ADDR
m_write  output  1  master write request
m_writedata  output  32  {24'b0, pattern}
m_waitrequest  input  1  master stall from interconnect
busy  output  1  high when FSM not IDLE
step  output  3  index of the current step

Behaviour:
- Interface: one clock `clk`. Reset is synchronous, active-high, named `reset`.
- Slave write strobe: chipselect && !write_n.
- Register map (word addresses):
  - 0 CTRL: bit0 RUN, bit1 LOOP (R/W).
  - 1 STATUS: bit0 busy, bit1 DONE (sticky; writing 1 to bit1 clears it), bits[6:4] step.
  - 2 DWELL: [CNT_W-1:0]. Value 0 is treated as 1.
  - 3 LENGTH: [3:0]. Value 0 is treated as 1; values >DEPTH are clamped to DEPTH.
  - 8..8+DEPTH-1 PATTERN[i]: bits[7:0].
  - Unused addresses and unused bits read 0.
- Reset:
  - CTRL, STATUS, DWELL and LENGTH clear to 0.
  - All patterns clear to 0x00.
  - m_write=0, m_writedata=0, busy=0, step=0, FSM=IDLE.
  - Reset mid-transfer drops m_write on the next edge without waiting for m_waitrequest.
- FSM states: IDLE, WRITE, DWELL.
  - IDLE: when RUN=1, load step=0, clear DONE, go to WRITE.
  - WRITE:
    - m_write=1; m_writedata holds PATTERN[step] captured on entry.
    - m_writedata must stay stable while m_waitrequest=1.
    - On a cycle with m_waitrequest=0: the transfer completes and the dwell counter loads max(DWELL,1); go to DWELL.
  - DWELL:
    - Counter decrements once per cycle; exits when it reaches 1.
    - If step==LEN-1 and LOOP=1: step=0, go to WRITE.
    - If step==LEN-1 and LOOP=0: set DONE, clear RUN, go to IDLE.
    - Otherwise: step+1, go to WRITE.
- Timing: CTRL write in cycle N puts m_write=1 in cycle N+1. With zero wait states the step period is DWELL+1 cycles.
- RUN cleared by software:
  - In DWELL: FSM goes to IDLE on the next edge. The LEDs keep the last pattern.
  - In WRITE: the current transfer finishes first, then the FSM goes to IDLE.
- Updates while running:
  - PATTERN writes take effect when the slot is next fetched.
  - DWELL and LENGTH are sampled at counter load and at step advance, respectively.
- Simultaneous events:
  - A software write to STATUS.DONE in the same cycle the FSM sets DONE: the set wins.
  - A software write to CTRL in the same cycle the FSM clears RUN: the software write wins.
- The FSM never issues two overlapping requests.

Test Plan:
- Reset, then read registers 0-3 and 8-15 -> all 0; m_write=0; busy=0.
- LENGTH=3, DWELL=4, PATTERN={0x01,0x02,0x04}, LOOP=0, RUN=1; m_waitrequest=0 -> writes 0x01, 0x02, 0x04 spaced 5 cycles apart; DONE=1; RUN=0; busy=0.
- Same setup with LOOP=1 -> write sequence 0x01,0x02,0x04,0x01,...; clear RUN during a dwell -> no further writes; the last pattern remains on out_port.
- m_waitrequest held high for 3 cycles on the second write -> m_write and m_writedata=0x02 held stable for 4 cycles; the dwell starts after acceptance.
- DWELL=0, LENGTH=0, RUN=1 -> one write of PATTERN[0]; DONE one cycle later (step period 2).
- Assert reset while m_write=1 and m_waitrequest=1 -> m_write=0 next cycle; all registers at reset values.

Source files
------------

// File: rtl/led_sequencer.sv
// LED pattern sequencer: software loads patterns, dwell and length over an Avalon-MM slave;
// the FSM then writes each pattern to the LED PIO over an Avalon-MM master and holds it.
module led_sequencer #(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned CNT_W    = 24,
   parameter logic [1:0]  PIO_ADDR = 2'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [1:0]  m_address,
   output logic        m_write,
   output logic [31:0] m_writedata,
   input  logic        m_waitrequest,
   output logic        busy,
   output logic [2:0]  step
);

   localparam int unsigned IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  DepthW = 4'(DEPTH);

   typedef enum logic [1:0] {StIdle, StWrite, StDwell} state_e;

   state_e           state_q, state_d;
   logic             run_q, run_d, loop_q, loop_d, done_q, done_d;
   logic [CNT_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
   logic [3:0]       len_q, len_d;
   logic [2:0]       step_q, step_d;
   logic [7:0]       wdata_q, wdata_d;
   logic [7:0]       pattern_q [DEPTH];
   logic [7:0]       pattern_d [DEPTH];

   logic             sw_wr, ctrl_wr, run_sw, loop_sw, last_step;
   logic             fsm_set_done, fsm_clr_done, fsm_clr_run;
   logic [3:0]       len_eff;
   logic [CNT_W-1:0] dwell_load;
   logic             unused_wdata;

   assign sw_wr   = chipselect && !write_n;
   assign ctrl_wr = sw_wr && (address == 4'd0);
   // The FSM reacts to a CTRL write in the same cycle it is issued.
   assign run_sw  = ctrl_wr ? writedata[0] : run_q;
   assign loop_sw = ctrl_wr ? writedata[1] : loop_q;

   assign unused_wdata = ^writedata;

   always_comb begin
      if (len_q == 4'd0) begin
         len_eff = 4'd1;
      end else if (len_q > DepthW) begin
         len_eff = DepthW;
      end else begin
         len_eff = len_q;
      end
   end

   // Treat any step at or beyond the end as last, in case LENGTH shrank mid-run.
   assign last_step  = ({1'b0, step_q} >= (len_eff - 4'd1));
   assign dwell_load = (dwell_q == '0) ? CNT_W'(1) : dwell_q;

   always_comb begin
      state_d      = state_q;
      step_d       = step_q;
      cnt_d        = cnt_q;
      wdata_d      = wdata_q;
      fsm_set_done = 1'b0;
      fsm_clr_done = 1'b0;
      fsm_clr_run  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (run_sw) begin
               step_d       = '0;
               fsm_clr_done = 1'b1;
               state_d      = StWrite;
            end
         end
         StWrite: begin
            if (!m_waitrequest) begin
               if (!run_sw) begin
                  state_d = StIdle;
               end else begin
                  cnt_d   = dwell_load;
                  state_d = StDwell;
               end
            end
         end
         StDwell: begin
            if (!run_sw) begin
               state_d = StIdle;
            end else if (cnt_q > CNT_W'(1)) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (!last_step) begin
               step_d  = step_q + 3'd1;
               state_d = StWrite;
            end else if (loop_sw) begin
               step_d  = '0;
               state_d = StWrite;
            end else begin
               fsm_set_done = 1'b1;
               fsm_clr_run  = 1'b1;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if ((state_d == StWrite) && (state_q != StWrite)) begin
         wdata_d = pattern_q[step_d[IW-1:0]];
      end
   end

   always_comb begin
      run_d     = run_sw;
      loop_d    = loop_sw;
      done_d    = done_q;
      dwell_d   = dwell_q;
      len_d     = len_q;
      pattern_d = pattern_q;
      if (fsm_clr_run && !ctrl_wr) run_d = 1'b0;
      if (fsm_clr_done) done_d = 1'b0;
      if (sw_wr) begin
         case (address)
            4'd1: if (writedata[1]) done_d = 1'b0;
            4'd2: dwell_d = writedata[CNT_W-1:0];
            4'd3: len_d = writedata[3:0];
            default: begin
               if (address[3] && ({1'b0, address[2:0]} < DepthW)) begin
                  pattern_d[address[IW-1:0]] = writedata[7:0];
               end
            end
         endcase
      end
      // A completion in the same cycle as a software clear keeps DONE set.
      if (fsm_set_done) done_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         run_q     <= 1'b0;
         loop_q    <= 1'b0;
         done_q    <= 1'b0;
         dwell_q   <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         step_q    <= '0;
         wdata_q   <= '0;
         pattern_q <= '{default: '0};
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         loop_q    <= loop_d;
         done_q    <= done_d;
         dwell_q   <= dwell_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         step_q    <= step_d;
         wdata_q   <= wdata_d;
         pattern_q <= pattern_d;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         4'd0: readdata[1:0] = {loop_q, run_q};
         4'd1: begin
            readdata[0]   = busy;
            readdata[1]   = done_q;
            readdata[6:4] = step_q;
         end
         4'd2: readdata[CNT_W-1:0] = dwell_q;
         4'd3: readdata[3:0] = len_q;
         default: begin
            if (address[3] && ({1'b0, address[2:0]} < DepthW)) begin
               readdata[7:0] = pattern_q[address[IW-1:0]];
            end
         end
      endcase
   end

   assign m_address   = PIO_ADDR;
   assign m_write     = (state_q == StWrite);
   assign m_writedata = {24'b0, wdata_q};
   assign busy        = (state_q != StIdle);
   assign step        = step_q;

endmodule
